// File: rtl/mont_convert_if.sv
// Request/result bundle for mont_convert: plain operand and modulus in, Montgomery-domain results out.
interface mont_convert_if #(
  parameter int WIDTH = 512
);
  // Handshake: valid_in is a request strobe sampled only while the block is
  // idle (busy_out low and no result pending); there is no ready and no queuing,
  // so a requester must wait for valid_out before issuing the next request.
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] modulo;
  logic             valid_in;
  logic [WIDTH-1:0] base_mont_out;
  logic [WIDTH-1:0] one_mont_out;
  logic             valid_out;
  logic             busy_out;
  logic             error_out;
  logic [1:0]       state_dbg;

  modport master (
    output x_in, modulo, valid_in,
    input  base_mont_out, one_mont_out, valid_out, busy_out, error_out, state_dbg
  );

  modport slave (
    input  x_in, modulo, valid_in,
    output base_mont_out, one_mont_out, valid_out, busy_out, error_out, state_dbg
  );
endinterface

// File: rtl/mont_convert.sv
// Converts x into Montgomery form (x*2^WIDTH mod N) and produces 2^WIDTH mod N by WIDTH modular doublings.
// Optional operand range check enabled by defining MONT_CONVERT_RANGE_CHECK_EN.
module mont_convert #(
  parameter int WIDTH = 512
) (
  input  logic         clk_in,
  input  logic         rst_in,
  mont_convert_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DOUBLE = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] one_q;
  logic             valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] a_dbl;
  logic [WIDTH-1:0] b_dbl;

  // One doubling step; a single subtraction suffices because v < n keeps 2v < 2n.
  function automatic logic [WIDTH-1:0] mod_dbl(input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] n);
    logic [WIDTH:0] t;
    t = {v, 1'b0};
    if (t >= {1'b0, n}) t = t - {1'b0, n};
    return t[WIDTH-1:0];
  endfunction

  assign a_dbl = mod_dbl(a_q, n_q);
  assign b_dbl = mod_dbl(b_q, n_q);

`ifdef MONT_CONVERT_RANGE_CHECK_EN
  logic error_q;
  logic bad_req;
  assign bad_req = (bus.x_in >= bus.modulo) || !bus.modulo[0] || (bus.modulo == '0);
  assign bus.error_out = error_q;
`else
  assign bus.error_out = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      base_q  <= '0;
      one_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MONT_CONVERT_RANGE_CHECK_EN
      error_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_in) begin
`ifdef MONT_CONVERT_RANGE_CHECK_EN
            if (bad_req) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              error_q <= 1'b1;
              base_q  <= '0;
              one_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
`endif
              a_q     <= bus.x_in;
              // 1 mod 1 is 0; seeding B with 1 would leave it stuck at 1.
              b_q     <= (bus.modulo == WIDTH'(1)) ? '0 : WIDTH'(1);
              n_q     <= bus.modulo;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= DOUBLE;
`ifdef MONT_CONVERT_RANGE_CHECK_EN
            end
`endif
          end
        end
        DOUBLE: begin
          a_q   <= a_dbl;
          b_q   <= b_dbl;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            base_q  <= a_dbl;
            one_q   <= b_dbl;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
`ifdef MONT_CONVERT_RANGE_CHECK_EN
          error_q <= 1'b0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.base_mont_out = base_q;
  assign bus.one_mont_out  = one_q;
  assign bus.valid_out     = valid_q;
  assign bus.busy_out      = busy_q;
  assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_mont_convert.sv
// Directed bench for mont_convert at WIDTH=8 (R=256) with an expected-result queue and a decoupled monitor.
module tb_mont_convert;
  localparam int WIDTH = 8;
  localparam int EW    = 1 + 32 + WIDTH + WIDTH;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  // Entry layout: {error, expected valid cycle, one_mont, base_mont}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;

  mont_convert_if #(.WIDTH(WIDTH)) bus ();

  mont_convert #(.WIDTH(WIDTH)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Issues one request; lat is the number of cycles from acceptance to valid_out.
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] m,
                      input logic [WIDTH-1:0] eb, input logic [WIDTH-1:0] eo,
                      input logic ee, input int lat);
    @(negedge clk);
    bus.x_in     = x;
    bus.modulo   = m;
    bus.valid_in = 1'b1;
    exp_q.push_back({ee, 32'(cyc + 1 + lat), eo, eb});
    @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_done();
    repeat (WIDTH + 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.valid_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("base_mont", 64'(bus.base_mont_out), 64'(e[WIDTH-1:0]));
        chk("one_mont", 64'(bus.one_mont_out), 64'(e[2*WIDTH-1:WIDTH]));
        chk("error", 64'(bus.error_out), 64'(e[EW-1]));
        chk("valid_cycle", 64'(cyc), 64'(e[2*WIDTH+31:2*WIDTH]));
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.x_in     = '0;
    bus.modulo   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 64'(bus.valid_out), 64'd0);
    chk("rst_busy", 64'(bus.busy_out), 64'd0);
    chk("rst_error", 64'(bus.error_out), 64'd0);
    chk("rst_base", 64'(bus.base_mont_out), 64'd0);
    chk("rst_one", 64'(bus.one_mont_out), 64'd0);
    chk("rst_state", 64'(bus.state_dbg), 64'd0);

    // 5*256 mod 13 = 6, 256 mod 13 = 9
    send(8'd5, 8'd13, 8'd6, 8'd9, 1'b0, WIDTH);
    chk("busy_in_flight", 64'(bus.busy_out), 64'd1);
    wait_done();
    send(8'd0, 8'd13, 8'd0, 8'd9, 1'b0, WIDTH);
    wait_done();
    // 256 mod 255 = 1
    send(8'd7, 8'd255, 8'd7, 8'd1, 1'b0, WIDTH);
    wait_done();
    send(8'd0, 8'd1, 8'd0, 8'd0, 1'b0, WIDTH);
    wait_done();

    // Held request: accepted every 10 cycles; 12*9 mod 13 = 4
    @(negedge clk);
    bus.x_in     = 8'd12;
    bus.modulo   = 8'd13;
    bus.valid_in = 1'b1;
    for (int k = 0; k < 3; k++)
      exp_q.push_back({1'b0, 32'(cyc + 1 + 10 * k + WIDTH), 8'd9, 8'd4});
    repeat (25) @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (12) @(negedge clk);

    // Reset three cycles into a conversion aborts it
    send(8'd5, 8'd13, 8'd6, 8'd9, 1'b0, WIDTH);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(bus.busy_out), 64'd0);
    chk("abort_base", 64'(bus.base_mont_out), 64'd0);
    repeat (12) @(negedge clk);
    send(8'd5, 8'd13, 8'd6, 8'd9, 1'b0, WIDTH);
    wait_done();

    // Inputs changing after acceptance must not disturb the result
    send(8'd5, 8'd13, 8'd6, 8'd9, 1'b0, WIDTH);
    @(negedge clk);
    bus.modulo = 8'd11;
    bus.x_in   = 8'd9;
    wait_done();

`ifdef MONT_CONVERT_RANGE_CHECK_EN
    send(8'd13, 8'd13, 8'd0, 8'd0, 1'b1, 0);
    wait_done();
    send(8'd1, 8'd12, 8'd0, 8'd0, 1'b1, 0);
    wait_done();
    send(8'd5, 8'd13, 8'd6, 8'd9, 1'b0, WIDTH);
    wait_done();
`endif

    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mont_convert.md
MONT_CONVERT -- requirements
Module: mont_convert

Interface
REQ-001 The block SHALL have parameter WIDTH, default 512, giving the operand width in bits.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high (clk_in, rst_in).
REQ-003 Port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-005 Port x_in, input, WIDTH bits: plain-domain operand to convert.
REQ-006 Port modulo, input, WIDTH bits: modulus N.
REQ-007 Port valid_in, input, 1 bit: request strobe, sampled only in IDLE.
REQ-008 Port base_mont_out, output, WIDTH bits: x_in*R mod N, with R = 2^WIDTH.
REQ-009 Port one_mont_out, output, WIDTH bits: R mod N, the Montgomery form of 1.
REQ-010 Port valid_out, output, 1 bit: single-cycle result strobe.
REQ-011 Port busy_out, output, 1 bit: high while a conversion is in flight.
REQ-012 Port error_out, output, 1 bit: range-check failure flag, qualified by valid_out.

Function
REQ-013 States SHALL be IDLE, DOUBLE and DONE.
REQ-014 IDLE with valid_in=1 at edge E0: capture x_in into accumulator A, load 1 into accumulator B, capture modulo into Nreg, clear counter, set busy_out=1, go to DOUBLE.
REQ-015 Every DOUBLE edge SHALL update each of A and B with t=2*v (WIDTH+1 bits); if t >= {1'b0,Nreg} then t-Nreg, otherwise t; result truncated to WIDTH bits.
REQ-016 After exactly WIDTH doublings (edge E_WIDTH), base_mont_out SHALL take A and one_mont_out SHALL take B, valid_out=1, busy_out=0, state goes to DONE.
REQ-017 Latency: valid_out SHALL be high in the cycle following edge E_WIDTH, i.e. WIDTH cycles after the acceptance edge, for exactly one cycle.
REQ-018 DONE SHALL clear valid_out and return to IDLE on the next edge; a new request is accepted no earlier than the edge after DONE.
REQ-019 valid_in SHALL be ignored in DOUBLE and DONE; no queuing.
REQ-020 Changes on x_in or modulo after E0 SHALL NOT affect the result in flight.
REQ-021 base_mont_out and one_mont_out SHALL hold their last values until the next result.
REQ-022 The single conditional subtraction SHALL be exact when A < Nreg and B < Nreg, which holds for x_in < modulo and modulo > 1.
REQ-023 If modulo == 1, both outputs SHALL be 0.
REQ-024 If x_in >= modulo and the range check is compiled out, output values are unspecified; valid_out timing is unchanged.

Reset
REQ-025 While rst_in=1 at an edge, the block SHALL set state=IDLE, counter=0, valid_out=0, busy_out=0, error_out=0, base_mont_out=0 and one_mont_out=0.
REQ-026 Reset mid-conversion SHALL abort it with no valid_out; the next request after reset SHALL compute correctly.

Configuration
REQ-027 Macro MONT_CONVERT_RANGE_CHECK_EN SHALL select range checking.
REQ-028 With the macro defined: at E0, if x_in >= modulo, modulo is even, or modulo == 0, the block SHALL skip DOUBLE, go directly to DONE with valid_out=1, error_out=1, both outputs 0 and busy_out=0; a valid request SHALL give error_out=0 with valid_out.
REQ-029 Without the macro: error_out SHALL be tied 0, no check logic, and every request SHALL take the full WIDTH-cycle path.

Verification (bench uses WIDTH=8, R=256)
REQ-030 x_in=5, modulo=13 -> base_mont_out=6, one_mont_out=9, valid_out high for 1 cycle, 8 cycles after the acceptance edge.
REQ-031 x_in=0, modulo=13, then x_in=7, modulo=255 -> (0,9), then (7,1).
REQ-032 Hold valid_in=1 continuously with x_in=12, modulo=13 -> one result (4,9) per 10-cycle period; no request accepted in DOUBLE or DONE.
REQ-033 Assert rst_in for one cycle 3 cycles into a conversion -> no valid_out; the following request x_in=5, modulo=13 gives (6,9).
REQ-034 Change modulo from 13 to 11 two cycles after acceptance -> result still (6,9) for x_in=5.
REQ-035 With MONT_CONVERT_RANGE_CHECK_EN: x_in=13, modulo=13 and x_in=1, modulo=12 -> valid_out and error_out in the cycle after the DONE-entry edge, outputs 0; x_in=5, modulo=13 -> error_out=0, (6,9).
